// File: rtl/ones_builder.sv
// ones_builder: builds a word whose low N bits are set, one bit per clock, under a start/done handshake
module ones_builder #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_DONE} state_t;

    localparam logic [CW-1:0] WMAX = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic             busy_q, done_q;

    // next-state and datapath: start only from idle, shift in a one per remaining count
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: if (s) begin
                state_d     = S_BUILD;
                result_d    = '0;
                remaining_d = (count > WMAX) ? WMAX : count;
            end
            S_BUILD: if (remaining_q != '0) begin
                result_d    = {result_q[WIDTH-2:0], 1'b1};
                remaining_d = remaining_q - 1'b1;
            end else begin
                state_d = S_DONE;
            end
            S_DONE: state_d = s ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state register; busy/done are registered decodes of the next state so they track state exactly
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            remaining_q <= remaining_d;
            busy_q      <= (state_d == S_BUILD);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_ones_builder.sv
// tb_ones_builder: table-driven and hand-sequenced checks of ones_builder with a result/latency scoreboard
module tb_ones_builder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s = 1'b0;
    logic [3:0] count = '0;
    logic [7:0] result;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] c;
        logic [7:0] r;
        int         lat;
        int         hold;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        int         lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    ones_builder #(.WIDTH(8), .CW(4)) dut (
        .clk(clk), .reset(reset), .s(s), .count(count),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a start, record the expectation, and move to just after the accepting edge
    task automatic launch(input logic [3:0] c, input logic [7:0] r, input int lat);
        sb.push_back('{r, lat});
        s = 1'b1;
        count = c;
        step();
    endtask

    // wait (bounded) for done, then compare against the oldest scoreboard entry
    task automatic finish_build(input int lat0);
        exp_t e;
        int lat = lat0;
        int busy_n = lat0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("done_latency", lat, e.lat);
        chk("busy_cycles", busy_n, e.lat);
        chk("result", result, e.r);
        chk("busy_low_at_done", busy, 0);
    endtask

    initial begin
        vecs[0] = '{4'd3,  8'h07, 4, 0};
        vecs[1] = '{4'd0,  8'h00, 1, 0};
        vecs[2] = '{4'd8,  8'hFF, 9, 0};
        vecs[3] = '{4'd15, 8'hFF, 9, 0};
        vecs[4] = '{4'd5,  8'h1F, 6, 5};
        vecs[5] = '{4'd1,  8'h01, 2, 0};
        vecs[6] = '{4'd7,  8'h7F, 8, 2};
        vecs[7] = '{4'd2,  8'h03, 3, 0};

        reset = 1'b0;
        s = 1'b1;
        count = 4'd3;
        step();
        step();
        chk("reset_result", result, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        reset = 1'b1;
        s = 1'b0;
        count = 4'd9;
        step();
        step();
        chk("idle_hold_busy", busy, 0);
        chk("idle_hold_result", result, 8'h00);

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].c, vecs[i].r, vecs[i].lat);
            finish_build(0);
            for (int h = 0; h < vecs[i].hold; h++) begin
                step();
                chk("hold_done", done, 1);
                chk("hold_busy", busy, 0);
                chk("hold_result", result, vecs[i].r);
            end
            s = 1'b0;
            step();
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_result", result, vecs[i].r);
        end

        launch(4'd5, 8'h1F, 6);
        step();
        count = 4'd2;
        s = 1'b0;
        finish_build(1);
        step();
        chk("abort_ignored_idle", done, 0);
        chk("abort_ignored_result", result, 8'h1F);

        s = 1'b1;
        count = 4'd6;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        chk("midreset_result", result, 8'h00);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        step();
        chk("midreset_hold_busy", busy, 0);
        reset = 1'b1;
        launch(4'd2, 8'h03, 3);
        finish_build(0);
        s = 1'b0;
        step();
        chk("final_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
